// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared scan states and default panel geometry
package hub75_pkg;

    localparam int HPIXEL   = 64;
    localparam int VPIXEL   = 64;
    localparam int BPP      = 8;
    localparam int SEGMENTS = 2;

    typedef logic [2:0] scan_state_t;

    localparam scan_state_t IDLE      = 3'd0;
    localparam scan_state_t START     = 3'd1;
    localparam scan_state_t WAIT_ACK  = 3'd2;
    localparam scan_state_t WAIT_DONE = 3'd3;
    localparam scan_state_t BLANK     = 3'd4;
    localparam scan_state_t DISPLAY   = 3'd5;

endpackage

// File: rtl/hub75_bcm_timer.sv
// rtl/hub75_bcm_timer.sv - loadable down-counter timing the blank and BCM display phases
module hub75_bcm_timer #(
    parameter int WIDTH_P = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [WIDTH_P-1:0] i_value,
    output logic               o_done
);

    logic [WIDTH_P-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A phase loaded with N stays active for exactly N cycles: it exits on the cycle showing 1.
    assign o_done = (r_count <= WIDTH_P'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - frame/row/bit-plane sequencer driving the HUB75 shifter and OE
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter  int hpixel_p        = HPIXEL,
    parameter  int vpixel_p        = VPIXEL,
    parameter  int bpp_p           = BPP,
    parameter  int segments_p      = SEGMENTS,
    localparam int rows_p          = vpixel_p / segments_p,
    localparam int row_w_p         = $clog2(rows_p),
    localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
    localparam int pix_bit_width_p = $clog2(bpp_p),
    localparam int cnt_w_p         = 16 + bpp_p
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_enable,
    input  logic [15:0]                i_base_time,
    input  logic [7:0]                 i_blank_cycles,
    output logic                       o_tx_start,
    output logic [addr_width_p-1:0]    o_init_addr,
    output logic [pix_bit_width_p-1:0] o_pix_bit,
    input  logic                       i_tx_ready,
    output logic [row_w_p-1:0]         o_row_addr,
    output logic                       o_oe_n,
    output logic                       o_frame_done,
    output logic                       o_busy
);

    localparam logic [pix_bit_width_p-1:0] BIT_MSB  = pix_bit_width_p'(bpp_p - 1);
    localparam logic [row_w_p-1:0]         ROW_LAST = row_w_p'(rows_p - 1);

    scan_state_t                r_state;
    logic [row_w_p-1:0]         r_row;
    logic [pix_bit_width_p-1:0] r_bit;
    logic [addr_width_p-1:0]    r_init_addr;
    logic [pix_bit_width_p-1:0] r_pix_bit;
    logic [row_w_p-1:0]         r_row_addr;
    logic                       r_oe_n;
    logic                       r_tx_start;
    logic                       r_frame_done;

    logic                       w_load;
    logic [cnt_w_p-1:0]         w_value;
    logic [cnt_w_p-1:0]         w_blank_val;
    logic [cnt_w_p-1:0]         w_disp_shift;
    logic [cnt_w_p-1:0]         w_disp_val;
    logic [addr_width_p-1:0]    w_init_addr;
    logic                       w_done;

    assign w_blank_val  = (i_blank_cycles == 8'd0) ? cnt_w_p'(1) : cnt_w_p'(i_blank_cycles);
    assign w_disp_shift = cnt_w_p'(i_base_time) << r_bit;
    assign w_disp_val   = (w_disp_shift == '0) ? cnt_w_p'(1) : w_disp_shift;
    assign w_init_addr  = addr_width_p'(r_row) * addr_width_p'(hpixel_p);

    // Timer is reloaded on the same edge that enters BLANK or DISPLAY, so the
    // timing inputs are sampled exactly once per phase.
    always_comb begin
        w_load  = 1'b0;
        w_value = w_blank_val;
        if (r_state == WAIT_DONE && i_tx_ready) begin
            w_load  = 1'b1;
            w_value = w_blank_val;
        end else if (r_state == BLANK && w_done) begin
            w_load  = 1'b1;
            w_value = w_disp_val;
        end
    end

    hub75_bcm_timer #(.WIDTH_P(cnt_w_p)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_value),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_bit        <= BIT_MSB;
            r_init_addr  <= '0;
            r_pix_bit    <= BIT_MSB;
            r_row_addr   <= '0;
            r_oe_n       <= 1'b1;
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_oe_n <= 1'b1;
                    if (i_enable) begin
                        r_row   <= '0;
                        r_bit   <= BIT_MSB;
                        r_state <= START;
                    end
                end
                START: begin
                    r_init_addr <= w_init_addr;
                    r_pix_bit   <= r_bit;
                    if (i_tx_ready) begin
                        r_tx_start <= 1'b1;
                        r_state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!i_tx_ready) r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_tx_ready) begin
                        r_row_addr <= r_row;
                        r_oe_n     <= 1'b1;
                        r_state    <= BLANK;
                    end
                end
                BLANK: begin
                    if (w_done) begin
                        r_oe_n  <= 1'b0;
                        r_state <= DISPLAY;
                    end
                end
                DISPLAY: begin
                    if (w_done) begin
                        r_oe_n <= 1'b1;
                        if (r_bit != '0) begin
                            r_bit <= r_bit - 1'b1;
                        end else begin
                            r_bit <= BIT_MSB;
                            if (r_row == ROW_LAST) begin
                                r_row        <= '0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end
                        r_state <= i_enable ? START : IDLE;
                    end
                end
                default: begin
                    r_oe_n  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_tx_start   = r_tx_start;
    assign o_init_addr  = r_init_addr;
    assign o_pix_bit    = r_pix_bit;
    assign o_row_addr   = r_row_addr;
    assign o_oe_n       = r_oe_n;
    assign o_frame_done = r_frame_done;
    assign o_busy       = (r_state != IDLE);

endmodule
